// File: rtl/common_pkg.sv
// Shared branch-prediction types: branch kinds, BTB entry layout and 2-bit counter states.
package common;

    typedef enum logic [1:0] {
        BrCond = 2'b00,
        BrJump = 2'b01,
        BrCall = 2'b10,
        BrRet  = 2'b11
    } br_type_e;

    // Wide enough for the smallest BTB index; unused upper bits stay zero.
    localparam int unsigned BTB_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        br_type_e             br_type;
    } btb_entry_t;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with speculative push/pop and pointer restore on mispredict.
module return_addr_stack
    import common::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         spec_push,
    input  logic                         spec_pop,
    input  logic [31:0]                  spec_addr,
    input  logic                         restore,
    input  logic [$clog2(RAS_DEPTH)-1:0] restore_ptr,
    input  logic                         restore_push,
    input  logic                         restore_pop,
    input  logic [31:0]                  restore_addr,
    output logic [31:0]                  top_addr,
    output logic [$clog2(RAS_DEPTH)-1:0] ptr
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [31:0]      stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, wr_idx;
    logic             wr_en;
    logic [31:0]      wr_data;

    // A restore replays the resolved call/return on top of the snapshot pointer.
    always_comb begin
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = spec_addr;
        if (restore) begin
            ptr_d = restore_ptr;
            if (restore_push) begin
                wr_en   = 1'b1;
                wr_idx  = restore_ptr;
                wr_data = restore_addr;
                ptr_d   = restore_ptr + PTR_W'(1);
            end else if (restore_pop) begin
                ptr_d = restore_ptr - PTR_W'(1);
            end
        end else if (spec_push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
        end else if (spec_pop) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (wr_en) begin
                stack_q[wr_idx] <= wr_data;
            end
        end
    end

    assign top_addr = stack_q[ptr_q - PTR_W'(1)];
    assign ptr      = ptr_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare direction predictor plus direct-mapped BTB, with a return-address stack when
// BPU_RAS_EN is defined (otherwise returns use the BTB target).
module branch_predict_unit
    import common::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned GHR_BITS   = 8,
    parameter int unsigned BTB_BITS   = 5,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_pc,
    output logic                         pred_taken,
    output logic [31:0]                  pred_target,
    output logic [GHR_BITS-1:0]          pred_ghr,
    output logic [$clog2(RAS_DEPTH)-1:0] pred_ras_ptr,
    input  logic                         upd_valid,
    input  logic [31:0]                  upd_pc,
    input  logic [1:0]                   upd_type,
    input  logic                         upd_taken,
    input  logic [31:0]                  upd_target,
    input  logic [GHR_BITS-1:0]          upd_ghr,
    input  logic [$clog2(RAS_DEPTH)-1:0] upd_ras_ptr,
    input  logic                         upd_mispredict
);

    localparam int PHT_SIZE = 2 ** INDEX_BITS;
    localparam int BTB_SIZE = 2 ** BTB_BITS;

    logic [1:0]          pht_q [PHT_SIZE];
    btb_entry_t          btb_q [BTB_SIZE];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [BTB_BITS-1:0]   fetch_btb_idx, upd_btb_idx;
    logic [INDEX_BITS-1:0] fetch_pht_idx, upd_pht_idx;
    btb_entry_t            fetch_entry, btb_wdata;
    br_type_e              fetch_type, upd_kind;
    logic                  fetch_hit, fetch_dir, recover, btb_wr;
    logic [31:0]           fetch_seq, ras_top;

    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
        return BTB_TAG_W'(pc >> (BTB_BITS + 2));
    endfunction

    function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] h,
                                                      input logic t);
        return (h << 1) | GHR_BITS'(t);
    endfunction

    assign fetch_btb_idx = fetch_pc[BTB_BITS+1:2];
    assign fetch_entry   = btb_q[fetch_btb_idx];
    assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == tag_of(fetch_pc));
    assign fetch_type    = fetch_entry.br_type;
    assign fetch_pht_idx = fetch_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign fetch_dir     = pht_q[fetch_pht_idx][1];
    assign fetch_seq     = fetch_pc + 32'd4;

    assign upd_kind    = br_type_e'(upd_type);
    assign upd_btb_idx = upd_pc[BTB_BITS+1:2];
    assign upd_pht_idx = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_ghr);
    assign recover     = upd_valid && upd_mispredict;
    // Not-taken conditionals never allocate, so the BTB only holds redirecting branches.
    assign btb_wr      = upd_valid && (upd_taken || upd_kind != BrCond);

    always_comb begin
        btb_wdata         = '0;
        btb_wdata.valid   = 1'b1;
        btb_wdata.tag     = tag_of(upd_pc);
        btb_wdata.target  = upd_target;
        btb_wdata.br_type = upd_kind;
    end

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = fetch_seq;
        if (fetch_hit) begin
            unique case (fetch_type)
                BrCond: begin
                    pred_taken = fetch_dir;
                    if (fetch_dir) begin
                        pred_target = fetch_entry.target;
                    end
                end
                BrJump, BrCall: begin
                    pred_taken  = 1'b1;
                    pred_target = fetch_entry.target;
                end
                BrRet: begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end
            endcase
        end
    end

    // Mispredict recovery wins over the speculative shift from this cycle's fetch.
    always_comb begin
        ghr_d = ghr_q;
        if (recover) begin
            ghr_d = (upd_kind == BrCond) ? ghr_shift(upd_ghr, upd_taken) : upd_ghr;
        end else if (fetch_valid && fetch_hit && fetch_type == BrCond) begin
            ghr_d = ghr_shift(ghr_q, pred_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_q[i] <= CTR_WNT;
            end
            for (int i = 0; i < BTB_SIZE; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            ghr_q <= ghr_d;
            if (upd_valid && upd_kind == BrCond) begin
                pht_q[upd_pht_idx] <= ctr_next(pht_q[upd_pht_idx], upd_taken);
            end
            if (btb_wr) begin
                btb_q[upd_btb_idx] <= btb_wdata;
            end
        end
    end

    assign pred_ghr = ghr_q;

`ifdef BPU_RAS_EN
    logic spec_ok;
    assign spec_ok = fetch_valid && fetch_hit && !recover;

    return_addr_stack #(
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .spec_push   (spec_ok && fetch_type == BrCall),
        .spec_pop    (spec_ok && fetch_type == BrRet),
        .spec_addr   (fetch_seq),
        .restore     (recover),
        .restore_ptr (upd_ras_ptr),
        .restore_push(upd_kind == BrCall),
        .restore_pop (upd_kind == BrRet),
        .restore_addr(upd_pc + 32'd4),
        .top_addr    (ras_top),
        .ptr         (pred_ras_ptr)
    );
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{upd_ras_ptr, upd_pc[1:0]};
    assign ras_top           = fetch_entry.target;
    assign pred_ras_ptr      = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomised traffic
// compared every cycle against a behavioural predictor model.
module tb_branch_predict_unit;

`ifdef BPU_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic [1:0]  pred_ras_ptr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;
    logic [1:0]  upd_ras_ptr;
    logic        upd_mispredict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .INDEX_BITS(8),
        .GHR_BITS  (8),
        .BTB_BITS  (5),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ghr      (pred_ghr),
        .pred_ras_ptr  (pred_ras_ptr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_type      (upd_type),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_ghr       (upd_ghr),
        .upd_ras_ptr   (upd_ras_ptr),
        .upd_mispredict(upd_mispredict)
    );

    // Behavioural model: counters as integers 0..3, BTB as parallel arrays, RAS as a ring.
    int          m_pht  [256];
    bit          m_bv   [32];
    int unsigned m_btag [32];
    logic [31:0] m_btgt [32];
    int          m_btyp [32];
    logic [31:0] m_ras  [4];
    int          m_ghr;
    int          m_rp;
    bit          m_init = 1'b0;

    function automatic void m_predict(input logic [31:0] pc, output bit hit, output int typ,
                                      output bit tk, output logic [31:0] tgt);
        int e;
        e   = int'((pc / 4) % 32);
        hit = m_bv[e] && (m_btag[e] == pc / 128);
        typ = m_btyp[e];
        tk  = 1'b0;
        tgt = pc + 32'd4;
        if (hit) begin
            if (typ == 0) begin
                if (m_pht[int'((pc / 4) % 256) ^ m_ghr] >= 2) begin
                    tk  = 1'b1;
                    tgt = m_btgt[e];
                end
            end else if (typ == 3 && RAS_EN) begin
                tk  = 1'b1;
                tgt = m_ras[(m_rp + 3) % 4];
            end else begin
                tk  = 1'b1;
                tgt = m_btgt[e];
            end
        end
    endfunction

    task automatic m_step();
        bit          hit, tk;
        int          typ, k, e;
        logic [31:0] tgt;
        if (!reset_n) begin
            foreach (m_pht[i]) m_pht[i] = 1;
            foreach (m_bv[i]) m_bv[i] = 1'b0;
            foreach (m_ras[i]) m_ras[i] = '0;
            m_ghr  = 0;
            m_rp   = 0;
            m_init = 1'b1;
            return;
        end
        m_predict(fetch_pc, hit, typ, tk, tgt);
        if (upd_valid && upd_type == 2'd0) begin
            k = int'((upd_pc / 4) % 256) ^ int'(upd_ghr);
            if (upd_taken) m_pht[k] = (m_pht[k] < 3) ? m_pht[k] + 1 : 3;
            else           m_pht[k] = (m_pht[k] > 0) ? m_pht[k] - 1 : 0;
        end
        if (upd_valid && (upd_taken || upd_type != 2'd0)) begin
            e         = int'((upd_pc / 4) % 32);
            m_bv[e]   = 1'b1;
            m_btag[e] = upd_pc / 128;
            m_btgt[e] = upd_target;
            m_btyp[e] = int'(upd_type);
        end
        if (upd_valid && upd_mispredict) begin
            m_ghr = (upd_type == 2'd0) ? (int'(upd_ghr) * 2 + int'(upd_taken)) % 256
                                       : int'(upd_ghr);
            if (RAS_EN) begin
                m_rp = int'(upd_ras_ptr);
                if (upd_type == 2'd2) begin
                    m_ras[m_rp] = upd_pc + 32'd4;
                    m_rp = (m_rp + 1) % 4;
                end else if (upd_type == 2'd3) begin
                    m_rp = (m_rp + 3) % 4;
                end
            end
        end else if (fetch_valid && hit) begin
            if (typ == 0) m_ghr = (m_ghr * 2 + int'(tk)) % 256;
            if (RAS_EN && typ == 2) begin
                m_ras[m_rp] = fetch_pc + 32'd4;
                m_rp = (m_rp + 1) % 4;
            end else if (RAS_EN && typ == 3) begin
                m_rp = (m_rp + 3) % 4;
            end
        end
    endtask

    always @(posedge clk) m_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit          hit, tk;
        int          typ;
        logic [31:0] tgt;
        if (m_init) begin
            m_predict(fetch_pc, hit, typ, tk, tgt);
            check("pred_taken", 32'(pred_taken), 32'(tk));
            check("pred_target", pred_target, tgt);
            check("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
            check("pred_ras_ptr", 32'(pred_ras_ptr), RAS_EN ? 32'(m_rp) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                       input logic [31:0] tgt, input logic [7:0] ghr, input logic [1:0] rp,
                       input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_type       = typ;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_ghr        = ghr;
        upd_ras_ptr    = rp;
        upd_mispredict = misp;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        if ($urandom_range(0, 1) == 1) pc = pc + 32'h80;
        return pc;
    endfunction

    initial begin
        reset_n        = 1'b0;
        fetch_valid    = 1'b0;
        fetch_pc       = 32'h100;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_type       = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_ghr        = '0;
        upd_ras_ptr    = '0;
        upd_mispredict = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset_taken", 32'(pred_taken), 32'd0);
        check("reset_target", pred_target, 32'h104);
        check("reset_ghr", 32'(pred_ghr), 32'd0);
        step();

        // Counter training up and back down.
        repeat (3) upd(32'h200, 2'd0, 1'b1, 32'h180, 8'h00, 2'd0, 1'b0);
        fetch_pc = 32'h200;
        @(negedge clk);
        check("trained_taken", 32'(pred_taken), 32'd1);
        check("trained_target", pred_target, 32'h180);
        step();
        repeat (4) upd(32'h200, 2'd0, 1'b0, 32'h180, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        check("untrained_taken", 32'(pred_taken), 32'd0);
        check("untrained_target", pred_target, 32'h204);
        step();

        // Mispredict overrides the same-cycle fetch shift.
        fetch_valid = 1'b1;
        upd(32'h240, 2'd0, 1'b1, 32'h280, 8'h5A, 2'd0, 1'b1);
        fetch_valid = 1'b0;
        @(negedge clk);
        check("recover_ghr", 32'(pred_ghr), 32'hB5);
        step();

        // Call then return.
        upd(32'h300, 2'd2, 1'b1, 32'h500, 8'h00, 2'd0, 1'b0);
        upd(32'h404, 2'd3, 1'b1, 32'h600, 8'h00, 2'd0, 1'b0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h300;
        @(negedge clk);
        check("call_target", pred_target, 32'h500);
        step();
        fetch_pc = 32'h404;
        @(negedge clk);
        check("ret_taken", 32'(pred_taken), 32'd1);
        check("ret_target", pred_target, RAS_EN ? 32'h304 : 32'h600);
        step();
        fetch_valid = 1'b0;

        // Five nested calls overflow a 4-deep stack, then four returns.
        for (int i = 1; i <= 5; i++) upd(32'(i * 16), 2'd2, 1'b1, 32'h800, 8'h00, 2'd0, 1'b0);
        upd(32'h908, 2'd3, 1'b1, 32'hA00, 8'h00, 2'd0, 1'b0);
        fetch_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            fetch_pc = 32'(i * 16);
            step();
        end
        fetch_pc = 32'h908;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("nested_ret_target", pred_target, RAS_EN ? 32'(32'h54 - j * 16) : 32'hA00);
            step();
        end
        fetch_valid = 1'b0;

        // Direct-mapped aliasing: 0x1080 evicts 0x1000.
        upd(32'h1000, 2'd1, 1'b1, 32'h2000, 8'h00, 2'd0, 1'b0);
        upd(32'h1080, 2'd1, 1'b1, 32'h3000, 8'h00, 2'd0, 1'b0);
        fetch_pc = 32'h1000;
        @(negedge clk);
        check("alias_evicted_taken", 32'(pred_taken), 32'd0);
        check("alias_evicted_target", pred_target, 32'h1004);
        step();
        fetch_pc = 32'h1080;
        @(negedge clk);
        check("alias_hit_target", pred_target, 32'h3000);
        step();

        // Reset mid-operation clears the BTB and ignores a concurrent update.
        fetch_valid = 1'b1;
        reset_n     = 1'b0;
        upd(32'h1080, 2'd1, 1'b1, 32'h4444, 8'h33, 2'd1, 1'b1);
        reset_n     = 1'b1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("midreset_taken", 32'(pred_taken), 32'd0);
        check("midreset_target", pred_target, 32'h1084);
        check("midreset_ghr", 32'(pred_ghr), 32'd0);
        step();

        // Randomised traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            reset_n        = ($urandom_range(0, 499) != 0);
            fetch_valid    = ($urandom_range(0, 3) != 0);
            fetch_pc       = rand_pc();
            upd_valid      = ($urandom_range(0, 2) == 0);
            upd_pc         = rand_pc();
            upd_type       = 2'($urandom_range(0, 3));
            upd_taken      = 1'($urandom_range(0, 1));
            upd_target     = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
            upd_ghr        = ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom_range(0, 255));
            upd_ras_ptr    = 2'($urandom_range(0, 3));
            upd_mispredict = ($urandom_range(0, 7) == 0);
            step();
        end
        reset_n        = 1'b1;
        fetch_valid    = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
